// File: rtl/ether_frame_parser.sv
// ---------------------------------------------------------------------------
// ether_frame_parser
//
// Receive-side Ethernet header parser for a 32-bit AXI-stream frame. Captures
// the L2/L3 header fields needed by the ACL rule matcher and counts the frame
// length. It also classifies each frame as IPv4, TCP, runt or oversize, and
// presents one result per frame on a valid/ready handshake. While a result is
// waiting to be taken, the input stream is held off.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   i_rxd_tvalid   stream beat valid
//   i_rxd_tdata    stream beat data, big-endian (first byte in [31:24])
//   i_rxd_tlast    last beat of frame
//   o_rxd_tready   parser can accept a beat
//   o_hdr_valid    result fields valid
//   i_hdr_ready    downstream accepts the result
//   o_dst_mac      destination MAC
//   o_src_mac      source MAC
//   o_ethertype    Ethertype
//   o_ip_proto     IPv4 protocol byte
//   o_src_ip       IPv4 source address
//   o_dst_ip       IPv4 destination address
//   o_word_count   beats in the frame including tlast, saturating
//   o_is_ipv4      Ethertype == 0x0800
//   o_is_tcp       IPv4 and protocol == 0x06
//   o_runt         word count below MIN_WORDS
//   o_oversize     word count above MAX_WORDS
//   o_hdr_short    tlast arrived before beat 8
// ---------------------------------------------------------------------------
module ether_frame_parser #(
    parameter int MAX_WORDS = 380,
    parameter int MIN_WORDS = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rxd_tvalid,
    input  logic [31:0]      i_rxd_tdata,
    input  logic             i_rxd_tlast,
    output logic             o_rxd_tready,
    output logic             o_hdr_valid,
    input  logic             i_hdr_ready,
    output logic [47:0]      o_dst_mac,
    output logic [47:0]      o_src_mac,
    output logic [15:0]      o_ethertype,
    output logic [7:0]       o_ip_proto,
    output logic [31:0]      o_src_ip,
    output logic [31:0]      o_dst_ip,
    output logic [CNT_W-1:0] o_word_count,
    output logic             o_is_ipv4,
    output logic             o_is_tcp,
    output logic             o_runt,
    output logic             o_oversize,
    output logic             o_hdr_short
);

    localparam logic [1:0] ST_HDR     = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_RESULT  = 2'd2;

    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_WORDS);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] HDR_LAST_C = CNT_W'(8);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic f_is_ipv4(input logic [15:0] etype);
        return etype == 16'h0800;
    endfunction

    function automatic logic f_is_tcp(input logic [15:0] etype, input logic [7:0] proto);
        return f_is_ipv4(etype) && (proto == 8'h06);
    endfunction

    function automatic logic f_runt(input logic [CNT_W-1:0] wc);
        return wc < MIN_C;
    endfunction

    function automatic logic f_oversize(input logic [CNT_W-1:0] wc);
        return wc > MAX_C;
    endfunction

    // ------------------------------------------------------------------
    // Control and working registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tready_q, tready_d;
    logic             hvalid_q, hvalid_d;

    logic [47:0]      dst_mac_q, dst_mac_d;
    logic [47:0]      src_mac_q, src_mac_d;
    logic [15:0]      etype_q, etype_d;
    logic [7:0]       proto_q, proto_d;
    logic [31:0]      src_ip_q, src_ip_d;
    logic [31:0]      dst_ip_q, dst_ip_d;

    // Result registers, loaded once per frame when tlast is accepted
    logic [47:0]      res_dst_mac_q;
    logic [47:0]      res_src_mac_q;
    logic [15:0]      res_etype_q;
    logic [7:0]       res_proto_q;
    logic [31:0]      res_src_ip_q;
    logic [31:0]      res_dst_ip_q;
    logic [CNT_W-1:0] res_wc_q;
    logic             res_ipv4_q;
    logic             res_tcp_q;
    logic             res_runt_q;
    logic             res_over_q;
    logic             res_short_q;

    logic beat_acc;
    logic last_acc;

    // cnt_q is the index n of the beat currently offered on the stream.
    assign beat_acc = i_rxd_tvalid & tready_q;
    assign last_acc = beat_acc & i_rxd_tlast;

    // ------------------------------------------------------------------
    // Next-state, beat counting and header capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dst_mac_d = dst_mac_q;
        src_mac_d = src_mac_q;
        etype_d   = etype_q;
        proto_d   = proto_q;
        src_ip_d  = src_ip_q;
        dst_ip_d  = dst_ip_q;

        case (state_q)
            ST_HDR: begin
                if (beat_acc) begin
                    cnt_d = sat_inc(cnt_q);
                    if (i_rxd_tlast) begin
                        state_d = ST_RESULT;
                    end else begin
                        // The tlast beat never contributes header fields, so
                        // a frame ending on beat 8 still reports dst_ip[15:0]=0.
                        case (cnt_q)
                            CNT_W'(0): dst_mac_d[47:16] = i_rxd_tdata;
                            CNT_W'(1): begin
                                dst_mac_d[15:0]  = i_rxd_tdata[31:16];
                                src_mac_d[47:32] = i_rxd_tdata[15:0];
                            end
                            CNT_W'(2): src_mac_d[31:0]  = i_rxd_tdata;
                            CNT_W'(3): etype_d          = i_rxd_tdata[31:16];
                            CNT_W'(5): proto_d          = i_rxd_tdata[7:0];
                            CNT_W'(6): src_ip_d[31:16]  = i_rxd_tdata[15:0];
                            CNT_W'(7): begin
                                src_ip_d[15:0]  = i_rxd_tdata[31:16];
                                dst_ip_d[31:16] = i_rxd_tdata[15:0];
                            end
                            CNT_W'(8): dst_ip_d[15:0]   = i_rxd_tdata[31:16];
                            default: ;
                        endcase
                        if (cnt_q == HDR_LAST_C) begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (beat_acc) begin
                    cnt_d = sat_inc(cnt_q);
                    if (i_rxd_tlast) begin
                        state_d = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (i_hdr_ready) begin
                    state_d   = ST_HDR;
                    cnt_d     = '0;
                    dst_mac_d = '0;
                    src_mac_d = '0;
                    etype_d   = '0;
                    proto_d   = '0;
                    src_ip_d  = '0;
                    dst_ip_d  = '0;
                end
            end
            default: begin
                state_d = ST_HDR;
                cnt_d   = '0;
            end
        endcase

        // Registered handshake outputs follow the next state, so tready drops
        // on the same edge that accepts tlast and returns on the edge that
        // completes the result handshake.
        tready_d = (state_d != ST_RESULT);
        hvalid_d = (state_d == ST_RESULT);
    end

    // ------------------------------------------------------------------
    // Control and working field registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_HDR;
            cnt_q     <= '0;
            tready_q  <= 1'b0;
            hvalid_q  <= 1'b0;
            dst_mac_q <= '0;
            src_mac_q <= '0;
            etype_q   <= '0;
            proto_q   <= '0;
            src_ip_q  <= '0;
            dst_ip_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tready_q  <= tready_d;
            hvalid_q  <= hvalid_d;
            dst_mac_q <= dst_mac_d;
            src_mac_q <= src_mac_d;
            etype_q   <= etype_d;
            proto_q   <= proto_d;
            src_ip_q  <= src_ip_d;
            dst_ip_q  <= dst_ip_d;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: stable from tlast acceptance until the next frame ends
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_dst_mac_q <= '0;
            res_src_mac_q <= '0;
            res_etype_q   <= '0;
            res_proto_q   <= '0;
            res_src_ip_q  <= '0;
            res_dst_ip_q  <= '0;
            res_wc_q      <= '0;
            res_ipv4_q    <= 1'b0;
            res_tcp_q     <= 1'b0;
            res_runt_q    <= 1'b0;
            res_over_q    <= 1'b0;
            res_short_q   <= 1'b0;
        end else if (last_acc) begin
            res_dst_mac_q <= dst_mac_q;
            res_src_mac_q <= src_mac_q;
            res_etype_q   <= etype_q;
            res_proto_q   <= proto_q;
            res_src_ip_q  <= src_ip_q;
            res_dst_ip_q  <= dst_ip_q;
            res_wc_q      <= cnt_d;
            res_ipv4_q    <= f_is_ipv4(etype_q);
            res_tcp_q     <= f_is_tcp(etype_q, proto_q);
            res_runt_q    <= f_runt(cnt_d);
            res_over_q    <= f_oversize(cnt_d);
            res_short_q   <= (cnt_q < HDR_LAST_C);
        end
    end

    assign o_rxd_tready = tready_q;
    assign o_hdr_valid  = hvalid_q;
    assign o_dst_mac    = res_dst_mac_q;
    assign o_src_mac    = res_src_mac_q;
    assign o_ethertype  = res_etype_q;
    assign o_ip_proto   = res_proto_q;
    assign o_src_ip     = res_src_ip_q;
    assign o_dst_ip     = res_dst_ip_q;
    assign o_word_count = res_wc_q;
    assign o_is_ipv4    = res_ipv4_q;
    assign o_is_tcp     = res_tcp_q;
    assign o_runt       = res_runt_q;
    assign o_oversize   = res_over_q;
    assign o_hdr_short  = res_short_q;

endmodule

// File: tb/tb_ether_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_ether_frame_parser
//
// Directed sequence of frames with randomized payload/header words. Expected
// results come from a frame-level reference model that works on the whole
// list of words of a frame.
// ---------------------------------------------------------------------------
module tb_ether_frame_parser;

    localparam int MAX_WORDS = 380;
    localparam int MIN_WORDS = 16;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_rxd_tvalid;
    logic [31:0]      i_rxd_tdata;
    logic             i_rxd_tlast;
    logic             o_rxd_tready;
    logic             o_hdr_valid;
    logic             i_hdr_ready;
    logic [47:0]      o_dst_mac;
    logic [47:0]      o_src_mac;
    logic [15:0]      o_ethertype;
    logic [7:0]       o_ip_proto;
    logic [31:0]      o_src_ip;
    logic [31:0]      o_dst_ip;
    logic [CNT_W-1:0] o_word_count;
    logic             o_is_ipv4;
    logic             o_is_tcp;
    logic             o_runt;
    logic             o_oversize;
    logic             o_hdr_short;

    always #5 clk = ~clk;

    ether_frame_parser #(
        .MAX_WORDS(MAX_WORDS),
        .MIN_WORDS(MIN_WORDS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rxd_tvalid (i_rxd_tvalid),
        .i_rxd_tdata  (i_rxd_tdata),
        .i_rxd_tlast  (i_rxd_tlast),
        .o_rxd_tready (o_rxd_tready),
        .o_hdr_valid  (o_hdr_valid),
        .i_hdr_ready  (i_hdr_ready),
        .o_dst_mac    (o_dst_mac),
        .o_src_mac    (o_src_mac),
        .o_ethertype  (o_ethertype),
        .o_ip_proto   (o_ip_proto),
        .o_src_ip     (o_src_ip),
        .o_dst_ip     (o_dst_ip),
        .o_word_count (o_word_count),
        .o_is_ipv4    (o_is_ipv4),
        .o_is_tcp     (o_is_tcp),
        .o_runt       (o_runt),
        .o_oversize   (o_oversize),
        .o_hdr_short  (o_hdr_short)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int accepted = 0;
    int hs_cnt   = 0;

    logic [31:0] frame_q[$];
    logic [31:0] std_words[9];

    logic [47:0]      exp_dst_mac;
    logic [47:0]      exp_src_mac;
    logic [15:0]      exp_etype;
    logic [7:0]       exp_proto;
    logic [31:0]      exp_src_ip;
    logic [31:0]      exp_dst_ip;
    logic [CNT_W-1:0] exp_wc;
    logic             exp_ipv4;
    logic             exp_tcp;
    logic             exp_runt;
    logic             exp_over;
    logic             exp_short;

    // Completed result handshakes
    always @(posedge clk) begin
        if (o_hdr_valid && i_hdr_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: header fields come from fixed word positions,
    // and only words before the tlast word count as reached.
    task automatic model();
        int n;
        logic [31:0] w[9];
        n = frame_q.size();
        for (int i = 0; i < 9; i++) w[i] = (i < n - 1) ? frame_q[i] : 32'h0;
        exp_dst_mac = {w[0], w[1][31:16]};
        exp_src_mac = {w[1][15:0], w[2]};
        exp_etype   = w[3][31:16];
        exp_proto   = w[5][7:0];
        exp_src_ip  = {w[6][15:0], w[7][31:16]};
        exp_dst_ip  = {w[7][15:0], w[8][31:16]};
        exp_wc      = (n > (1 << CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(n);
        exp_ipv4    = (exp_etype == 16'h0800);
        exp_tcp     = exp_ipv4 && (exp_proto == 8'h06);
        exp_runt    = (n < MIN_WORDS);
        exp_over    = (n > MAX_WORDS);
        exp_short   = (n <= 8);
    endtask

    task automatic check_result(input string tag);
        chk({tag, ".dst_mac"},   64'(o_dst_mac),    64'(exp_dst_mac));
        chk({tag, ".src_mac"},   64'(o_src_mac),    64'(exp_src_mac));
        chk({tag, ".ethertype"}, 64'(o_ethertype),  64'(exp_etype));
        chk({tag, ".ip_proto"},  64'(o_ip_proto),   64'(exp_proto));
        chk({tag, ".src_ip"},    64'(o_src_ip),     64'(exp_src_ip));
        chk({tag, ".dst_ip"},    64'(o_dst_ip),     64'(exp_dst_ip));
        chk({tag, ".word_count"},64'(o_word_count), 64'(exp_wc));
        chk({tag, ".is_ipv4"},   64'(o_is_ipv4),    64'(exp_ipv4));
        chk({tag, ".is_tcp"},    64'(o_is_tcp),     64'(exp_tcp));
        chk({tag, ".runt"},      64'(o_runt),       64'(exp_runt));
        chk({tag, ".oversize"},  64'(o_oversize),   64'(exp_over));
        chk({tag, ".hdr_short"}, 64'(o_hdr_short),  64'(exp_short));
    endtask

    task automatic build_frame(input int n, input bit use_std);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back($urandom());
        if (use_std) begin
            for (int i = 0; i < 9 && i < n; i++) frame_q[i] = std_words[i];
        end
    endtask

    // Drives the frame at negedges; tready seen at a negedge is the value
    // the next rising edge samples, so a beat with tvalid=1 is accepted then.
    task automatic send_frame(input int gap_pct);
        int guard;
        for (int i = 0; i < frame_q.size(); i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                i_rxd_tvalid = 1'b0;
                @(negedge clk);
            end
            i_rxd_tvalid = 1'b1;
            i_rxd_tdata  = frame_q[i];
            i_rxd_tlast  = (i == frame_q.size() - 1);
            guard = 0;
            while (!o_rxd_tready && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (!o_rxd_tready) begin
                chk("tready_timeout", 64'(o_rxd_tready), 64'd1);
                i_rxd_tvalid = 1'b0;
                i_rxd_tlast  = 1'b0;
                return;
            end
            @(negedge clk);
            accepted++;
        end
        i_rxd_tvalid = 1'b0;
        i_rxd_tlast  = 1'b0;
    endtask

    task automatic take_result(input string tag);
        i_hdr_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".valid_drop"}, 64'(o_hdr_valid),  64'd0);
        chk({tag, ".tready_back"},64'(o_rxd_tready), 64'd1);
        i_hdr_ready = 1'b0;
    endtask

    initial begin
        int h0;
        logic [31:0] held_w0;

        std_words = '{32'h8000_207A, 32'h3F3E_8000, 32'h2020_3AAE, 32'h0800_AAAA,
                      32'hBBBB_BBBB, 32'hCCCC_9906, 32'hDDDD_DDDD, 32'hFFFF_FFFF,
                      32'h1234_5678};
        rst          = 1'b0;
        i_rxd_tvalid = 1'b0;
        i_rxd_tdata  = '0;
        i_rxd_tlast  = 1'b0;
        i_hdr_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.tready",     64'(o_rxd_tready), 64'd0);
        chk("rst.valid",      64'(o_hdr_valid),  64'd0);
        chk("rst.word_count", 64'(o_word_count), 64'd0);
        chk("rst.dst_mac",    64'(o_dst_mac),    64'd0);
        chk("rst.hdr_short",  64'(o_hdr_short),  64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.tready_after", 64'(o_rxd_tready), 64'd1);
        chk("rst.valid_after",  64'(o_hdr_valid),  64'd0);

        // Standard TCP frame, 379 beats
        build_frame(379, 1'b1);
        model();
        send_frame(0);
        chk("std.latency", 64'(o_hdr_valid), 64'd1);
        chk("std.tready",  64'(o_rxd_tready), 64'd0);
        check_result("std");
        chk("std.dst_mac_lit", 64'(o_dst_mac), 64'h8000_207A_3F3E);
        chk("std.src_ip_lit",  64'(o_src_ip),  64'hDDDD_FFFF);
        chk("std.dst_ip_lit",  64'(o_dst_ip),  64'hFFFF_1234);
        take_result("std");

        // Oversize, 400 beats, drained fully with one result
        build_frame(400, 1'b1);
        model();
        accepted = 0;
        h0 = hs_cnt;
        send_frame(0);
        chk("over.latency", 64'(o_hdr_valid), 64'd1);
        check_result("over");
        take_result("over");
        repeat (3) @(negedge clk);
        chk("over.accepted", 64'(accepted),    64'd400);
        chk("over.results",  64'(hs_cnt - h0), 64'd1);
        chk("over.no_extra_valid", 64'(o_hdr_valid), 64'd0);

        // Runt and short header, tlast on beat 6
        build_frame(6, 1'b1);
        model();
        send_frame(0);
        check_result("runt");
        take_result("runt");

        // Single-beat frame
        build_frame(1, 1'b0);
        model();
        send_frame(0);
        check_result("one");
        take_result("one");

        // Nine beats: tlast on beat index 8
        build_frame(9, 1'b1);
        model();
        send_frame(0);
        check_result("nine");
        take_result("nine");

        // Back-pressure: hold ready low 10 cycles with next word0 offered
        build_frame(20, 1'b1);
        model();
        send_frame(0);
        held_w0      = $urandom();
        i_rxd_tvalid = 1'b1;
        i_rxd_tdata  = held_w0;
        i_rxd_tlast  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("bp.tready",     64'(o_rxd_tready), 64'd0);
            chk("bp.valid",      64'(o_hdr_valid),  64'd1);
            chk("bp.word_count", 64'(o_word_count), 64'(exp_wc));
            chk("bp.dst_ip",     64'(o_dst_ip),     64'(exp_dst_ip));
            @(negedge clk);
        end
        check_result("bp");
        take_result("bp");
        build_frame(15, 1'b0);
        frame_q[0] = held_w0;
        frame_q[3] = 32'h0800_0000;
        frame_q[5] = 32'h0000_0006;
        model();
        send_frame(0);
        check_result("bp2");
        take_result("bp2");

        // Non-IP with tvalid bubbles
        build_frame(20, 1'b1);
        frame_q[3] = 32'h86DD_0000;
        model();
        accepted = 0;
        send_frame(30);
        check_result("nonip");
        chk("nonip.accepted", 64'(accepted), 64'd20);
        take_result("nonip");

        // Reset mid-frame, then a fresh frame
        for (int i = 0; i < 5; i++) begin
            i_rxd_tvalid = 1'b1;
            i_rxd_tdata  = $urandom();
            i_rxd_tlast  = 1'b0;
            @(negedge clk);
        end
        i_rxd_tvalid = 1'b0;
        h0  = hs_cnt;
        rst = 1'b0;
        #1;
        chk("mid.rst_tready", 64'(o_rxd_tready), 64'd0);
        chk("mid.rst_wc",     64'(o_word_count), 64'd0);
        chk("mid.rst_valid",  64'(o_hdr_valid),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        build_frame(25, 1'b0);
        frame_q[3] = 32'h0800_1111;
        frame_q[5] = 32'h4500_0006;
        model();
        send_frame(0);
        chk("mid.latency", 64'(o_hdr_valid), 64'd1);
        check_result("mid");
        take_result("mid");
        chk("mid.results", 64'(hs_cnt - h0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
